axi_rchan_mux_2x1: RTL and testbench
====================================

// Module: axi_rchan_mux_2x1
// PURPOSE
//  Merges the AXI read-data (R) channels of two slaves back onto one master R channel.
//  Return path matching the 1x2 enable demux that fans master requests out to two slaves.
//  Round-robin arbitration at burst granularity: once granted, a slave owns the master R
//  channel until its RLAST beat is accepted. Registered output stage (one register slice).
// PARAMETERS
//  DATA_W   32   RDATA width in bits
//  ID_W     4    RID width in bits
// PORTS
//  ACLK        in   1       clock; all logic on rising edge
//  ARESETN     in   1       synchronous reset, active-low
//  S0_RDATA    in   DATA_W  slave 0 read data
//  S0_RRESP    in   2       slave 0 response
//  S0_RID      in   ID_W    slave 0 ID
//  S0_RLAST    in   1       slave 0 last beat of burst
//  S0_RVALID   in   1       slave 0 beat valid
//  S0_RREADY   out  1       ready to slave 0
//  S1_R*       (same set as S0, for slave 1)
//  M_RDATA     out  DATA_W  master read data (registered)
//  M_RRESP     out  2       master response (registered)
//  M_RID       out  ID_W    master ID (registered)
//  M_RLAST     out  1       master last beat (registered)
//  M_RVALID    out  1       master beat valid (registered)
//  M_RREADY    in   1       master ready
//  M_RSRC      out  1       source slave index of current M_R* beat (registered)
// BEHAVIOUR
//  Reset (ARESETN=0 at ACLK edge): state=IDLE, last_gnt=1, M_RVALID=0, M_RLAST=0,
//   M_RDATA/M_RRESP/M_RID/M_RSRC=0, S0_RREADY=S1_RREADY=0. Applies mid-burst; the
//   in-flight burst is discarded and no beat is replayed.
//  FSM states: IDLE, GNT0, GNT1.
//   IDLE: only S0_RVALID -> GNT0; only S1_RVALID -> GNT1; both -> slave != last_gnt;
//    none -> stay. S*_RREADY=0 in IDLE. last_gnt updated on entering GNTx.
//   GNTx: Sx_RREADY = !M_RVALID || M_RREADY; other slave's RREADY=0.
//    Beat accepted when Sx_RVALID && Sx_RREADY: M_R* <= Sx_R*, M_RSRC<=x, M_RVALID<=1.
//    Accepted beat with Sx_RLAST=1 -> IDLE next cycle; else stay GNTx.
//  Output slice: M_RVALID clears when M_RVALID && M_RREADY and no new beat accepted
//   same cycle; accept and drain in the same cycle sustains 1 beat/cycle.
//  M_R* stable while M_RVALID=1 && M_RREADY=0 (AXI rule); no combinational path from
//   S*_R* to M_R*. M_RREADY -> S*_RREADY path is combinational.
//  Latency: Sx_RVALID rises in IDLE at cycle n -> GNTx at n+1 -> beat accepted at n+1
//   -> M_RVALID=1 at n+2. Within a burst, 1 beat/cycle with M_RREADY=1.
//  Burst boundary costs one IDLE cycle (no beat accepted in IDLE).
//  Sx_RVALID dropping mid-burst: grant held; no timeout.
//  RRESP/RID/RLAST passed unmodified; no ID remap.
// TESTING
//  1. S0 4-beat burst D=0xA0..0xA3, M_RREADY=1 -> M sees A0..A3 on cycles n+2..n+5,
//     RLAST on A3, M_RSRC=0, RID/RRESP match.
//  2. S0,S1 valid same cycle after reset, 2-beat bursts each -> S0 burst complete first,
//     then IDLE cycle, then S1 burst; no interleaving.
//  3. Round-robin: S0 and S1 continuously requesting 1-beat bursts -> M_RSRC 0,1,0,1...
//  4. M_RREADY=0 for 3 cycles mid-burst -> M_RDATA/RLAST/RID held stable,
//     S0_RREADY=0, no beat lost or duplicated.
//  5. ARESETN=0 during beat 2 of 4 -> next cycle M_RVALID=0, state IDLE, S*_RREADY=0.
//     After release with S1 valid -> S1 granted (last_gnt=1 reset: S1 only requester).
//  6. S1 only, two back-to-back 3-beat bursts, M_RREADY=1 -> 6 beats, one 1-cycle gap
//     between bursts, M_RSRC=1 throughout.

Source files
------------

// File: rtl/axi_rchan_mux_2x1.sv
// Merges two slave AXI R channels onto one master R channel. Arbitration is
// round-robin per burst, and the master side goes through a one-entry register slice.
module axi_rchan_mux_2x1 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [DATA_W-1:0] S0_RDATA,
  input  logic [1:0]        S0_RRESP,
  input  logic [ID_W-1:0]   S0_RID,
  input  logic              S0_RLAST,
  input  logic              S0_RVALID,
  output logic              S0_RREADY,
  input  logic [DATA_W-1:0] S1_RDATA,
  input  logic [1:0]        S1_RRESP,
  input  logic [ID_W-1:0]   S1_RID,
  input  logic              S1_RLAST,
  input  logic              S1_RVALID,
  output logic              S1_RREADY,
  output logic [DATA_W-1:0] M_RDATA,
  output logic [1:0]        M_RRESP,
  output logic [ID_W-1:0]   M_RID,
  output logic              M_RLAST,
  output logic              M_RVALID,
  input  logic              M_RREADY,
  output logic              M_RSRC
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic [ID_W-1:0]   id;
    logic              last;
  } rbeat_t;

  logic [1:0] state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       slot_free;
  logic       accept;
  logic       accept_src;
  rbeat_t     s0_beat, s1_beat, sel_beat;

  assign s0_beat   = {S0_RDATA, S0_RRESP, S0_RID, S0_RLAST};
  assign s1_beat   = {S1_RDATA, S1_RRESP, S1_RID, S1_RLAST};
  assign sel_beat  = accept_src ? s1_beat : s0_beat;
  // Slice can take a beat when empty or when its current beat drains this cycle.
  assign slot_free = !M_RVALID || M_RREADY;

  // Grant register: the owner keeps the channel until its RLAST beat is taken
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state, slave ready and beat-accept decode
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    S0_RREADY    = 1'b0;
    S1_RREADY    = 1'b0;
    accept       = 1'b0;
    accept_src   = 1'b0;
    case (state)
      IDLE: begin
        if (S0_RVALID && (!S1_RVALID || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (S1_RVALID) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0: begin
        S0_RREADY = slot_free;
        if (S0_RVALID && slot_free) begin
          accept = 1'b1;
          if (S0_RLAST) state_nxt = IDLE;
        end
      end
      GNT1: begin
        S1_RREADY  = slot_free;
        accept_src = 1'b1;
        if (S1_RVALID && slot_free) begin
          accept = 1'b1;
          if (S1_RLAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register slice
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      M_RVALID <= 1'b0;
      M_RLAST  <= 1'b0;
      M_RDATA  <= '0;
      M_RRESP  <= '0;
      M_RID    <= '0;
      M_RSRC   <= 1'b0;
    end else if (accept) begin
      M_RVALID <= 1'b1;
      M_RLAST  <= sel_beat.last;
      M_RDATA  <= sel_beat.data;
      M_RRESP  <= sel_beat.resp;
      M_RID    <= sel_beat.id;
      M_RSRC   <= accept_src;
    end else if (M_RREADY) begin
      M_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rchan_mux_2x1.sv
// Scoreboard bench for axi_rchan_mux_2x1: slave drivers replay beat queues, and a
// monitor checks every master handshake against the expected-beat queue.
module tb_axi_rchan_mux_2x1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic        src;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] S0_RDATA, S1_RDATA, M_RDATA;
  logic [1:0]  S0_RRESP, S1_RRESP, M_RRESP;
  logic [3:0]  S0_RID, S1_RID, M_RID;
  logic        S0_RLAST, S1_RLAST, M_RLAST;
  logic        S0_RVALID, S1_RVALID, M_RVALID;
  logic        S0_RREADY, S1_RREADY, M_RREADY;
  logic        M_RSRC;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  beat_t s0_q[$];
  beat_t s1_q[$];
  beat_t exp_q[$];
  int    hs_cyc[$];

  axi_rchan_mux_2x1 #(.DATA_W(32), .ID_W(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RID(S0_RID), .S0_RLAST(S0_RLAST),
    .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RID(S1_RID), .S1_RLAST(S1_RLAST),
    .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RID(M_RID), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RSRC(M_RSRC)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] id,
                               input logic [1:0] resp, input logic last, input logic src);
    beat_t b;
    b.data = d; b.id = id; b.resp = resp; b.last = last; b.src = src;
    return b;
  endfunction

  // Slave 0 driver: pops the head beat after a handshake, presents the next one
  initial begin
    logic fire;
    S0_RVALID = 1'b0; S0_RDATA = '0; S0_RRESP = '0; S0_RID = '0; S0_RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      fire = S0_RVALID && S0_RREADY;
      @(posedge ACLK); #1;
      if (fire && s0_q.size() > 0) void'(s0_q.pop_front());
      if (s0_q.size() > 0) begin
        S0_RVALID = 1'b1; S0_RDATA = s0_q[0].data; S0_RID = s0_q[0].id;
        S0_RRESP = s0_q[0].resp; S0_RLAST = s0_q[0].last;
      end else begin
        S0_RVALID = 1'b0; S0_RDATA = '0; S0_RID = '0; S0_RRESP = '0; S0_RLAST = 1'b0;
      end
    end
  end

  initial begin
    logic fire;
    S1_RVALID = 1'b0; S1_RDATA = '0; S1_RRESP = '0; S1_RID = '0; S1_RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      fire = S1_RVALID && S1_RREADY;
      @(posedge ACLK); #1;
      if (fire && s1_q.size() > 0) void'(s1_q.pop_front());
      if (s1_q.size() > 0) begin
        S1_RVALID = 1'b1; S1_RDATA = s1_q[0].data; S1_RID = s1_q[0].id;
        S1_RRESP = s1_q[0].resp; S1_RLAST = s1_q[0].last;
      end else begin
        S1_RVALID = 1'b0; S1_RDATA = '0; S1_RID = '0; S1_RRESP = '0; S1_RLAST = 1'b0;
      end
    end
  end

  // Monitor: compares each master handshake and holds beats stable across stalls
  initial begin
    beat_t act, held, e;
    logic  stalled = 1'b0;
    forever begin
      @(negedge ACLK);
      act = mk(M_RDATA, M_RID, M_RRESP, M_RLAST, M_RSRC);
      if (ARESETN && stalled && M_RVALID) chk("stall hold", 64'(act), 64'(held));
      if (ARESETN && M_RVALID && M_RREADY) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected beat: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(act), 64'(e));
        end
      end
      stalled = ARESETN && M_RVALID && !M_RREADY;
      held    = act;
    end
  end

  task automatic wait_hs(input int n, input string nm);
    int t = 0;
    while (hs_cyc.size() < n && t < 60) begin
      @(negedge ACLK); #1;
      t++;
    end
    chk({nm, " timeout"}, 64'(hs_cyc.size() >= n), 64'd1);
  endtask

  task automatic do_reset(input int n);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    repeat (n) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  initial begin
    int base, t0;
    beat_t b;
    ARESETN  = 1'b0;
    M_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst m_rvalid",  64'(M_RVALID), 64'd0);
    chk("rst m_rlast",   64'(M_RLAST),  64'd0);
    chk("rst m_rdata",   64'(M_RDATA),  64'd0);
    chk("rst m_rid",     64'(M_RID),    64'd0);
    chk("rst m_rresp",   64'(M_RRESP),  64'd0);
    chk("rst m_rsrc",    64'(M_RSRC),   64'd0);
    chk("rst s0_rready", 64'(S0_RREADY), 64'd0);
    chk("rst s1_rready", 64'(S1_RREADY), 64'd0);
    @(posedge ACLK); #1 ARESETN = 1'b1;

    // 1: single S0 4-beat burst, latency and throughput
    @(negedge ACLK);
    base = hs_cyc.size(); t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      b = mk(32'hA0 + 32'(i), 4'h3, 2'b01, i == 3, 1'b0);
      s0_q.push_back(b); exp_q.push_back(b);
    end
    wait_hs(base + 4, "t1");
    chk("t1 first beat cycle", 64'(hs_cyc[base]),     64'(t0 + 3));
    chk("t1 last beat cycle",  64'(hs_cyc[base + 3]), 64'(t0 + 6));

    // 2: simultaneous requests after reset, S0 wins, no interleave, 1 idle cycle
    do_reset(2);
    @(negedge ACLK);
    base = hs_cyc.size();
    for (int i = 0; i < 2; i++) begin
      b = mk(32'h10 + 32'(i), 4'h1, 2'b00, i == 1, 1'b0);
      s0_q.push_back(b); exp_q.push_back(b);
    end
    for (int i = 0; i < 2; i++) begin
      b = mk(32'h20 + 32'(i), 4'h2, 2'b10, i == 1, 1'b1);
      s1_q.push_back(b);
    end
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(32'h20 + 32'(i), 4'h2, 2'b10, i == 1, 1'b1));
    wait_hs(base + 4, "t2");
    chk("t2 intra-burst gap", 64'(hs_cyc[base + 1] - hs_cyc[base]),     64'd1);
    chk("t2 burst boundary",  64'(hs_cyc[base + 2] - hs_cyc[base + 1]), 64'd2);

    // 3: round-robin with both slaves issuing 1-beat bursts
    @(negedge ACLK);
    base = hs_cyc.size();
    for (int i = 0; i < 3; i++) begin
      s0_q.push_back(mk(32'hB0 + 32'(i), 4'h5, 2'b00, 1'b1, 1'b0));
      s1_q.push_back(mk(32'hC0 + 32'(i), 4'h6, 2'b11, 1'b1, 1'b1));
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(32'hB0 + 32'(i), 4'h5, 2'b00, 1'b1, 1'b0));
      exp_q.push_back(mk(32'hC0 + 32'(i), 4'h6, 2'b11, 1'b1, 1'b1));
    end
    wait_hs(base + 6, "t3");

    // 4: master back-pressure mid-burst
    @(negedge ACLK);
    base = hs_cyc.size();
    for (int i = 0; i < 4; i++) begin
      b = mk(32'hD0 + 32'(i), 4'h7, 2'b01, i == 3, 1'b0);
      s0_q.push_back(b); exp_q.push_back(b);
    end
    wait_hs(base + 2, "t4 pre-stall");
    @(posedge ACLK); #1 M_RREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t4 stall s0_rready", 64'(S0_RREADY), 64'd0);
      chk("t4 stall m_rvalid",  64'(M_RVALID),  64'd1);
    end
    @(posedge ACLK); #1 M_RREADY = 1'b1;
    wait_hs(base + 4, "t4");

    // 5: reset during beat 2 of a 4-beat burst
    @(negedge ACLK);
    base = hs_cyc.size();
    for (int i = 0; i < 4; i++) s0_q.push_back(mk(32'hE0 + 32'(i), 4'h8, 2'b00, i == 3, 1'b0));
    exp_q.push_back(mk(32'hE0, 4'h8, 2'b00, 1'b0, 1'b0));
    wait_hs(base + 1, "t5 first beat");
    @(posedge ACLK); #1;
    ARESETN = 1'b0; M_RREADY = 1'b0;
    @(negedge ACLK);
    s0_q.delete();
    @(negedge ACLK);
    chk("t5 rst m_rvalid",  64'(M_RVALID),  64'd0);
    chk("t5 rst m_rlast",   64'(M_RLAST),   64'd0);
    chk("t5 rst s0_rready", 64'(S0_RREADY), 64'd0);
    chk("t5 rst s1_rready", 64'(S1_RREADY), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1; M_RREADY = 1'b1;
    @(negedge ACLK);
    base = hs_cyc.size(); t0 = cyc;
    b = mk(32'hF0, 4'h9, 2'b10, 1'b1, 1'b1);
    s1_q.push_back(b); exp_q.push_back(b);
    wait_hs(base + 1, "t5 s1");
    chk("t5 s1 latency", 64'(hs_cyc[base]), 64'(t0 + 3));

    // 6: S1 back-to-back 3-beat bursts
    @(negedge ACLK);
    base = hs_cyc.size();
    for (int i = 0; i < 6; i++) begin
      b = mk(32'h60 + 32'(i), 4'hC, 2'b00, (i == 2) || (i == 5), 1'b1);
      s1_q.push_back(b); exp_q.push_back(b);
    end
    wait_hs(base + 6, "t6");
    chk("t6 burst1 gap", 64'(hs_cyc[base + 2] - hs_cyc[base]),     64'd2);
    chk("t6 boundary",   64'(hs_cyc[base + 3] - hs_cyc[base + 2]), 64'd2);
    chk("t6 burst2 gap", 64'(hs_cyc[base + 5] - hs_cyc[base + 3]), 64'd2);

    repeat (5) @(negedge ACLK);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
